// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped UART transmitter on the CPU data-memory bus.
// A store to TXDATA pushes a byte into a small circular FIFO. An FSM pops bytes
// and serialises them LSB first as 8N1 frames on txd. STATUS and CTRL are read
// through a combinational port that the top level muxes into memreaddata.
// Optional feature macro: UART_TX_PARITY_EN adds an even-parity bit between the
// data bits and the stop bit, and sets STATUS bit4 to 1.
//
// Bus handshake: memwrite is a single-cycle store strobe qualified by memaddr.
// There is no ready/backpressure. A store to TXDATA while the FIFO is full is
// dropped and recorded in the sticky ovf flag. Reads are purely combinational
// and have no side effects.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'hFFFF_0000,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_AW      = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] memaddr,
  input  logic [31:0] memwritedata,
  output logic        sel,
  output logic [31:0] rdata,
  output logic        txd,
  output logic        busy,
  output logic [2:0]  dbg_state_o
);

  localparam int                 DEPTH       = 1 << FIFO_AW;
  localparam int                 BW          = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0]      BAUD_RELOAD = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0]      BAUD_ONE    = BW'(1);
  localparam logic [FIFO_AW:0]   PTR_ONE     = (FIFO_AW + 1)'(1);
`ifdef UART_TX_PARITY_EN
  localparam logic               PARITY_PRESENT = 1'b1;
`else
  localparam logic               PARITY_PRESENT = 1'b0;
`endif

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_STOP   = 3'd3,
    ST_PARITY = 3'd4
  } state_e;

  // ---------------------------------------------------------------------------
  // Address decode (full-word compare; byte offsets inside a word are not decoded)
  // ---------------------------------------------------------------------------
  logic wr_txdata;
  logic wr_ctrl;
  logic unused_wd;

  assign sel       = (memaddr[31:4] == BASE_ADDR[31:4]);
  assign wr_txdata = memwrite && (memaddr == BASE_ADDR);
  assign wr_ctrl   = memwrite && (memaddr == (BASE_ADDR + 32'h8));
  assign unused_wd = ^memwritedata[31:8];

  // ---------------------------------------------------------------------------
  // FIFO: circular buffer with one extra pointer bit to tell full from empty
  // ---------------------------------------------------------------------------
  logic [7:0]       mem_q [DEPTH];
  logic [FIFO_AW:0] wptr_q, wptr_d;
  logic [FIFO_AW:0] rptr_q, rptr_d;
  logic             empty;
  logic             full;
  logic             push;
  logic             pop;
  logic [7:0]       head;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[FIFO_AW] != rptr_q[FIFO_AW]) &&
                 (wptr_q[FIFO_AW-1:0] == rptr_q[FIFO_AW-1:0]);
  // full is judged before any same-cycle pop, so a push into a full FIFO drops
  assign push  = wr_txdata && !full;
  assign head  = mem_q[rptr_q[FIFO_AW-1:0]];

  // Pointer next-state: each pointer advances independently
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push) wptr_d = wptr_q + PTR_ONE;
    if (pop)  rptr_d = rptr_q + PTR_ONE;
  end

  // Pointer registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage array; contents are don't-care while the pointers say empty
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q[FIFO_AW-1:0]] <= memwritedata[7:0];
  end

  // ---------------------------------------------------------------------------
  // Control / status registers
  // ---------------------------------------------------------------------------
  logic en_q;
  logic ovf_q;

  // CTRL enable and sticky overflow flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en_q  <= 1'b1;
      ovf_q <= 1'b0;
    end else begin
      if (wr_ctrl) en_q <= memwritedata[0];
      if (wr_txdata && full)                ovf_q <= 1'b1;
      else if (wr_ctrl && memwritedata[1])  ovf_q <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Transmit FSM
  // ---------------------------------------------------------------------------
  state_e        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          txd_q, txd_d;
  logic          busy_q, busy_d;
`ifdef UART_TX_PARITY_EN
  logic          par_q, par_d;
`endif

  // Next-state and serial output; every state or bit change reloads the baud counter
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    txd_d   = txd_q;
    pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      ST_IDLE: begin
        txd_d = 1'b1;
        if (en_q && !empty) begin
          pop     = 1'b1;
          shift_d = head;
`ifdef UART_TX_PARITY_EN
          par_d   = ^head;
`endif
          state_d = ST_START;
          txd_d   = 1'b0;
          baud_d  = BAUD_RELOAD;
        end
      end
      ST_START: begin
        if (baud_q == '0) begin
          state_d = ST_DATA;
          txd_d   = shift_q[0];
          bit_d   = 3'd0;
          baud_d  = BAUD_RELOAD;
        end else begin
          baud_d = baud_q - BAUD_ONE;
        end
      end
      ST_DATA: begin
        if (baud_q == '0) begin
          baud_d = BAUD_RELOAD;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
            txd_d   = par_q;
`else
            state_d = ST_STOP;
            txd_d   = 1'b1;
`endif
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            txd_d   = shift_q[1];
          end
        end else begin
          baud_d = baud_q - BAUD_ONE;
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (baud_q == '0) begin
          state_d = ST_STOP;
          txd_d   = 1'b1;
          baud_d  = BAUD_RELOAD;
        end else begin
          baud_d = baud_q - BAUD_ONE;
        end
      end
`endif
      ST_STOP: begin
        if (baud_q == '0) begin
          baud_d = BAUD_RELOAD;
          // Chain straight into the next start bit so back-to-back frames have no gap
          if (en_q && !empty) begin
            pop     = 1'b1;
            shift_d = head;
`ifdef UART_TX_PARITY_EN
            par_d   = ^head;
`endif
            state_d = ST_START;
            txd_d   = 1'b0;
          end else begin
            state_d = ST_IDLE;
            txd_d   = 1'b1;
          end
        end else begin
          baud_d = baud_q - BAUD_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        txd_d   = 1'b1;
        baud_d  = '0;
      end
    endcase
    busy_d = (state_d != ST_IDLE) || (wptr_d != rptr_d);
  end

  // FSM state, counters, shift register and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign txd         = txd_q;
  assign busy        = busy_q;
  assign dbg_state_o = state_q;

  // ---------------------------------------------------------------------------
  // Combinational read port; unmapped offsets and TXDATA read as zero
  // ---------------------------------------------------------------------------
  always_comb begin
    rdata = '0;
    if (sel) begin
      case (memaddr[3:0])
        4'h4:    rdata = {27'b0, PARITY_PRESENT, ovf_q, busy_q, full, empty};
        4'h8:    rdata = {31'b0, en_q};
        default: rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: self-checking bench for mmio_uart_tx with CLKS_PER_BIT=4.
// A serial monitor decodes frames on txd and compares each byte with the head
// of the expected queue filled when the bytes are stored.
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE = 32'hFFFF_0000;
  localparam int          CPB  = 4;
`ifdef UART_TX_PARITY_EN
  localparam int          NBITS = 11;
`else
  localparam int          NBITS = 10;
`endif
  localparam int          FRAME = NBITS * CPB;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        memwrite = 1'b0;
  logic [31:0] memaddr = '0;
  logic [31:0] memwritedata = '0;
  logic        sel;
  logic [31:0] rdata;
  logic        txd;
  logic        busy;
  logic [2:0]  dbg_state;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          rx_cnt   = 0;
  int          start_t [64];
  logic [7:0]  exp_q [$];

  mmio_uart_tx #(
    .BASE_ADDR   (BASE),
    .CLKS_PER_BIT(CPB),
    .FIFO_AW     (3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .memwrite    (memwrite),
    .memaddr     (memaddr),
    .memwritedata(memwritedata),
    .sel         (sel),
    .rdata       (rdata),
    .txd         (txd),
    .busy        (busy),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Store: strobe is set up on a falling edge and captured on the next rising edge.
  // Returns on the falling edge just after that rising edge.
  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    memwrite     = 1'b1;
    memaddr      = addr;
    memwritedata = data;
    @(negedge clk);
    memwrite     = 1'b0;
    memaddr      = '0;
    memwritedata = '0;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] d, output logic s);
    memaddr = addr;
    #1;
    d = rdata;
    s = sel;
    memaddr = '0;
  endtask

  task automatic wait_frames(input int target, input int budget);
    for (int c = 0; c < budget && rx_cnt < target; c++) @(negedge clk);
  endtask

  task automatic wait_idle(input int budget);
    for (int c = 0; c < budget && busy !== 1'b0; c++) @(negedge clk);
  endtask

  // ---------------- serial monitor / scoreboard ----------------
  always begin : rx_mon
    logic [7:0] data;
    logic       bad;
    logic       par_bit;
    logic       stop_bit;
    int         t0;
    @(negedge clk);
    if (reset === 1'b1 && txd === 1'b0) begin
      t0       = cyc;
      bad      = 1'b0;
      data     = '0;
      par_bit  = 1'b0;
      stop_bit = 1'b0;
      for (int i = 1; i <= (NBITS - 1) * CPB + 1; i++) begin
        @(negedge clk);
        if (reset !== 1'b1) bad = 1'b1;
        if (i == CPB / 2 && !bad) check("rx_start", 32'(txd), 32'h0);
        if (i >= CPB + 1 && i <= 8 * CPB + 1 && ((i - 1) % CPB) == 0)
          data[(i - 1) / CPB - 1] = txd;
        if (i == 9 * CPB + 1) par_bit = txd;
        if (i == (NBITS - 1) * CPB + 1) stop_bit = txd;
      end
      if (!bad) begin
        start_t[rx_cnt % 64] = t0;
        rx_cnt++;
        if (exp_q.size() == 0) check("rx_unexpected_frame", 32'(data), 32'h100);
        else                   check("rx_data", 32'(data), 32'(exp_q.pop_front()));
        check("rx_stop", 32'(stop_bit), 32'h1);
`ifdef UART_TX_PARITY_EN
        check("rx_parity", 32'(par_bit), 32'(^data));
`else
        if (par_bit === 1'bx) check("rx_bit_x", 32'(par_bit), 32'h0);
`endif
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] d;
    logic        s;
    int          base;
    logic [7:0]  b;

    // Test 1: reset state
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("t1_txd", 32'(txd), 32'h1);
    check("t1_busy", 32'(busy), 32'h0);
    check("t1_state", 32'(dbg_state), 32'h0);
    bus_read(BASE + 32'h4, d, s);
    check("t1_status", d, 32'h1);
    check("t1_sel", 32'(s), 32'h1);
    bus_read(BASE + 32'h8, d, s);
    check("t1_ctrl", d, 32'h1);

    // Test 2: single frame timing
    exp_q.push_back(8'hA5);
    bus_write(BASE, 32'h1234_56A5);
    check("t2_busy_after_push", 32'(busy), 32'h1);
    check("t2_txd_before_start", 32'(txd), 32'h1);
    @(negedge clk);
    check("t2_start_low", 32'(txd), 32'h0);
    repeat (3) @(negedge clk);
    check("t2_start_held", 32'(txd), 32'h0);
    @(negedge clk);
    check("t2_bit0", 32'(txd), 32'h1);
    repeat (35) @(negedge clk);
    check("t2_busy_last_stop_cycle", 32'(busy), 32'h1);
    @(negedge clk);
    check("t2_busy_done", 32'(busy), 32'h0);
    check("t2_txd_idle", 32'(txd), 32'h1);

    // Test 3: overflow with transmitter disabled, then back-to-back drain
    bus_write(BASE + 32'h8, 32'h0);
    for (int i = 0; i < 9; i++) begin
      bus_write(BASE, 32'(i));
      if (i < 8) exp_q.push_back(8'(i));
    end
    bus_read(BASE + 32'h4, d, s);
    check("t3_status_full_ovf", d, 32'hE);
    check("t3_txd_held", 32'(txd), 32'h1);
    base = rx_cnt;
    bus_write(BASE + 32'h8, 32'h1);
    wait_frames(base + 8, 8 * FRAME + 60);
    check("t3_frame_count", 32'(rx_cnt - base), 32'h8);
    for (int j = 0; j < 7; j++)
      check("t3_no_gap", 32'(start_t[(base + j + 1) % 64] - start_t[(base + j) % 64]), 32'(FRAME));
    wait_idle(20);
    bus_read(BASE + 32'h4, d, s);
    check("t3_status_after_drain", d, 32'h9);

    // Test 4: clear ovf with enable kept
    bus_write(BASE + 32'h8, 32'h3);
    bus_read(BASE + 32'h4, d, s);
    check("t4_status", d, 32'h1);
    bus_read(BASE + 32'h8, d, s);
    check("t4_ctrl", d, 32'h1);

    // Random bytes, plus writes that must not push
    base = rx_cnt;
    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom_range(0, 255));
      exp_q.push_back(b);
      bus_write(BASE, {24'hABCDEF, b});
    end
    wait_frames(base + 4, 4 * FRAME + 60);
    check("rand_frame_count", 32'(rx_cnt - base), 32'h4);
    wait_idle(20);
    bus_write(BASE + 32'h4, 32'hFF);
    bus_write(BASE + 32'h1, 32'h55);
    bus_read(BASE + 32'h4, d, s);
    check("ignored_writes_status", d, 32'h1);
    check("ignored_writes_busy", 32'(busy), 32'h0);

    // Test 5: asynchronous reset mid-frame
    exp_q.push_back(8'h3C);
    bus_write(BASE, 32'h3C);
    @(negedge clk);
    check("t5_start_low", 32'(txd), 32'h0);
    repeat (10) @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("t5_txd_async", 32'(txd), 32'h1);
    check("t5_busy_async", 32'(busy), 32'h0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    bus_read(BASE + 32'h4, d, s);
    check("t5_status_after", d, 32'h1);
    repeat (FRAME) @(negedge clk);
    check("t5_txd_stays_idle", 32'(txd), 32'h1);

    // Test 6: unmapped offsets and the optional parity frame
    bus_read(BASE + 32'hC, d, s);
    check("t6_off_c_rdata", d, 32'h0);
    check("t6_off_c_sel", 32'(s), 32'h1);
    bus_read(32'hFFFE_FFFC, d, s);
    check("t6_outside_rdata", d, 32'h0);
    check("t6_outside_sel", 32'(s), 32'h0);
    bus_read(BASE + 32'h10, d, s);
    check("t6_above_sel", 32'(s), 32'h0);
`ifdef UART_TX_PARITY_EN
    bus_read(BASE + 32'h4, d, s);
    check("t6_status_parity", d, 32'h11);
    exp_q.push_back(8'h07);
    bus_write(BASE, 32'h07);
    @(negedge clk);
    check("t6_start_low", 32'(txd), 32'h0);
    repeat (FRAME - 1) @(negedge clk);
    check("t6_busy_last", 32'(busy), 32'h1);
    @(negedge clk);
    check("t6_busy_done", 32'(busy), 32'h0);
`endif

    repeat (10) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
